alu_result_accumulator: RTL
===========================

Name: alu_result_accumulator

Overview:
Downstream stage of the 4-bit add/subtract unit. It consumes that unit's 8-bit results, which it treats as signed two's-complement, through a valid/ready handshake. It sums a batch of BATCH_LEN results, or a shorter batch ended by flush, into a signed accumulator, then presents the sum, the sample count and a sticky overflow flag on an output valid/ready handshake.

Parameters:
BATCH_LEN, 4, results summed per batch (>=1)
ACC_W, 12, accumulator width in bits, signed (>=8)
CNT_W, $clog2(BATCH_LEN+1), localparam, width of the sample counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_result is valid this cycle
in_ready  output  1  block accepts a result this cycle
in_result  input  8  result from add/subtract unit, signed two's complement
flush  input  1  close the current partial batch
out_valid  output  1  out_sum, out_count and out_overflow are valid
out_ready  input  1  consumer takes the output this cycle
out_sum  output  ACC_W  signed batch sum
out_count  output  CNT_W  number of results in the batch
out_overflow  output  1  signed overflow occurred at any point in the batch

Behaviour:
- FSM states: ACCUM, DONE. Reset state is ACCUM.
- Reset values: acc=0, count=0, ovf=0, out_valid=0, in_ready=1. out_sum, out_count and out_overflow are driven directly from acc, count and ovf.
- in_ready = (state==ACCUM). out_valid = (state==DONE). Both are registered-state decodes with no combinational path from in_valid or out_ready.
- Accept occurs when in_valid && in_ready:
  - acc <= acc + sign_extend(in_result, ACC_W)
  - count <= count+1
  - ovf |= signed overflow of that add (operand signs equal, result sign differs). acc wraps modulo 2^ACC_W.
- Batch close: if an accept makes count reach BATCH_LEN, the next state is DONE. Latency: out_valid rises on the cycle after the last accept.
- flush in ACCUM:
  - count>0, or an accept in the same cycle: the accept (if any) is applied first, then DONE.
  - count==0 and no accept: ignored.
  - flush in DONE: ignored.
- DONE:
  - out_sum, out_count and out_overflow are held stable while out_ready=0.
  - No input is accepted in DONE (no bypass).
- DONE with out_ready=1: acc, count and ovf clear to 0, state goes to ACCUM. in_ready=1 on the next cycle.
- in_result is ignored when in_valid=0. in_valid may be held high indefinitely while in_ready=0 (backpressure).
- rst mid-operation: all state clears immediately. A partial batch is discarded with no output.

Decomposition:
- Shared package alu_pkg:
  - RESULT_W=8 (shared with the add/subtract unit)
  - state enum acc_state_t {ACCUM, DONE}
- One natural sub-module: sat_detect_add. Combinational signed ACC_W adder returning the sum and an overflow bit. The accumulator instantiates it once.

Test Plan:
1. Defaults; accept 0x03, 0x05, 0xFF, 0x02 back-to-back with out_ready=1 -> out_valid high on the cycle after the 4th accept; out_sum=9, out_count=4, out_overflow=0; in_ready returns to 1 the following cycle.
2. Full batch completes with out_ready=0 for 5 cycles and in_valid held high -> in_ready=0 and outputs stable for all 5 cycles. Raise out_ready -> one transfer, then acc=0 and the next result is accepted.
3. Accept 0x07, 0xF9, then pulse flush -> out_sum=0, out_count=2. flush with count==0 and in_valid=0 -> no state change. flush coincident with the 2nd accept -> out_count=2.
4. ACC_W=8 instance; accept 0x7F, 0x7F -> acc wraps to 0xFE; out_overflow=1 at batch end; flag clears after the output handshake.
5. Accept 2 results, assert rst for 1 cycle -> out_valid=0, count=0, in_ready=1. Next batch 0x01 x4 -> out_sum=4, with no residue from the discarded batch.
6. BATCH_LEN=1 -> every accepted result yields an output equal to its sign extension, e.g. 0x80 -> out_sum=0xF80 (-128).

Source files
------------

// File: rtl/alu_pkg.sv
// Definitions shared between the add/subtract unit and its result accumulator.
package alu_pkg;

    localparam int RESULT_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/sat_detect_add.sv
// Combinational signed adder that also reports two's-complement overflow.
module sat_detect_add #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         overflow
);

    // Overflow: both operands share a sign and the wrapped sum does not.
    always_comb begin
        sum      = a + b;
        overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    end

endmodule

// File: rtl/alu_result_accumulator.sv
// Sums batches of signed add/subtract results and hands each batch sum,
// its sample count and a sticky overflow flag to a downstream consumer.
module alu_result_accumulator
    import alu_pkg::*;
#(
    parameter  int BATCH_LEN = 4,
    parameter  int ACC_W     = 12,
    localparam int CNT_W     = $clog2(BATCH_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RESULT_W-1:0] in_result,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_sum,
    output logic [CNT_W-1:0]    out_count,
    output logic                out_overflow
);

    localparam logic [CNT_W-1:0] BATCH_CNT = CNT_W'(BATCH_LEN);

    acc_state_t       state_r;
    acc_state_t       next_state_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] next_acc_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] next_count_s;
    logic             ovf_r;
    logic             next_ovf_s;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [ACC_W-1:0] ext_s;
    logic [ACC_W-1:0] add_sum_s;
    logic             add_ovf_s;
    logic             accept_s;
    logic [CNT_W-1:0] count_inc_s;

    assign ext_s       = ACC_W'($signed(in_result));
    assign accept_s    = in_valid && in_ready_r;
    assign count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};

    sat_detect_add #(
        .W (ACC_W)
    ) u_add (
        .a        (acc_r),
        .b        (ext_s),
        .sum      (add_sum_s),
        .overflow (add_ovf_s)
    );

    // Next-state and datapath update; an accept is applied before any close.
    always_comb begin
        next_state_s = state_r;
        next_acc_s   = acc_r;
        next_count_s = count_r;
        next_ovf_s   = ovf_r;
        case (state_r)
            ACCUM: begin
                if (accept_s) begin
                    next_acc_s   = add_sum_s;
                    next_count_s = count_inc_s;
                    next_ovf_s   = ovf_r | add_ovf_s;
                end else begin
                    next_acc_s   = acc_r;
                    next_count_s = count_r;
                    next_ovf_s   = ovf_r;
                end
                if ((accept_s && (count_inc_s == BATCH_CNT)) ||
                    (flush && (accept_s || (count_r != {CNT_W{1'b0}})))) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = ACCUM;
                    next_acc_s   = {ACC_W{1'b0}};
                    next_count_s = {CNT_W{1'b0}};
                    next_ovf_s   = 1'b0;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = ACCUM;
                next_acc_s   = {ACC_W{1'b0}};
                next_count_s = {CNT_W{1'b0}};
                next_ovf_s   = 1'b0;
            end
        endcase
    end

    // State, datapath and handshake flops; handshakes are decoded from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ACCUM;
            acc_r       <= {ACC_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            acc_r       <= next_acc_s;
            count_r     <= next_count_s;
            ovf_r       <= next_ovf_s;
            in_ready_r  <= (next_state_s == ACCUM);
            out_valid_r <= (next_state_s == DONE);
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_sum      = acc_r;
    assign out_count    = count_r;
    assign out_overflow = ovf_r;

endmodule
